// File: rtl/serv_rf_ram_bridge.sv
// Bridges the core's two-port, chunk-serial register file stream onto a RAM with one
// read port and one write port, each `width` bits wide.
module serv_rf_ram_bridge #(
  parameter int unsigned width    = 8,
  parameter int unsigned W        = 1,
  parameter int unsigned WITH_CSR = 1,
  localparam int unsigned RW      = 5 + WITH_CSR,
  localparam int unsigned AW      = RW + $clog2(32 / width)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wreq,
  input  logic              i_rreq,
  output logic              o_ready,
  input  logic [RW-1:0]     i_wreg0,
  input  logic [RW-1:0]     i_wreg1,
  input  logic              i_wen0,
  input  logic              i_wen1,
  input  logic [W-1:0]      i_wdata0,
  input  logic [W-1:0]      i_wdata1,
  input  logic [RW-1:0]     i_rreg0,
  input  logic [RW-1:0]     i_rreg1,
  output logic [W-1:0]      o_rdata0,
  output logic [W-1:0]      o_rdata1,
  output logic [AW-1:0]     o_waddr,
  output logic [width-1:0]  o_wdata,
  output logic              o_wen,
  output logic [AW-1:0]     o_raddr,
  output logic              o_ren,
  input  logic [width-1:0]  i_rdata
);

  localparam int unsigned R      = width / W;
  localparam int unsigned RLg    = $clog2(R);
  localparam int unsigned WLg    = $clog2(32 / width);
  localparam int unsigned NChunk = 32 / W;
  localparam int unsigned CW     = $clog2(NChunk) + 1;
  // Read counter must survive at least until the o_ready slot.
  localparam int unsigned RLast  = (NChunk - 1 > 2) ? NChunk - 1 : 2;

  // Read side state
  logic              r_active_q, r_active_d;
  logic [CW-1:0]     r_cnt_q, r_cnt_d;
  logic              ren0_q, ren0_d;
  logic              ren1_q, ren1_d;
  logic [width-1:0]  rbuf0_q, rbuf0_d;
  logic [width-1:0]  rbuf1_q, rbuf1_d;

  // Write side state
  logic              w_active_q, w_active_d;
  logic [CW-1:0]     w_cnt_q, w_cnt_d;
  logic [width-1:0]  wbuf0_q, wbuf0_d;
  logic [width-1:0]  wbuf1_q, wbuf1_d;
  logic [width-1:0]  whold1_q, whold1_d;
  logic              wcommit0_q, wcommit0_d;
  logic              wcommit1_q, wcommit1_d;
  logic [CW-1:0]     wword_q, wword_d;

  logic              r_issue, ren0, ren1;
  logic [CW-1:0]     r_word;
  logic              w_sample, w_done;

  always_comb begin
    r_issue    = r_active_q && (r_cnt_q < CW'(NChunk));
    ren0       = r_issue && (r_cnt_q[RLg-1:0] == '0);
    ren1       = r_issue && (r_cnt_q[RLg-1:0] == RLg'(1));
    r_word     = r_cnt_q >> RLg;

    o_ren      = ren0 | ren1;
    o_raddr    = (AW'(ren1 ? i_rreg1 : i_rreg0) << WLg) | AW'(r_word);
    o_ready    = r_active_q && (r_cnt_q == CW'(2));

    r_active_d = r_active_q;
    r_cnt_d    = r_cnt_q;
    if (i_rreq) begin
      r_active_d = 1'b1;
      r_cnt_d    = '0;
    end else if (r_active_q) begin
      if (r_cnt_q == CW'(RLast)) r_active_d = 1'b0;
      else                       r_cnt_d    = r_cnt_q + 1'b1;
    end

    ren0_d  = ren0;
    ren1_d  = ren1;
    rbuf0_d = ren0_q ? i_rdata : (rbuf0_q >> W);
    // Port1 chunk 0 is bypassed straight from the RAM, so only the rest is stored.
    rbuf1_d = ren1_q ? (i_rdata >> W) : (rbuf1_q >> W);

    o_rdata0 = rbuf0_q[W-1:0];
    o_rdata1 = ren1_q ? i_rdata[W-1:0] : rbuf1_q[W-1:0];
  end

  always_comb begin
    // A fresh i_wreq discards whatever the old window would have sampled this cycle.
    w_sample   = w_active_q && !i_wreq;
    w_done     = w_sample && (w_cnt_q[RLg-1:0] == RLg'(R - 1));

    wbuf0_d    = w_sample ? {i_wdata0, wbuf0_q[width-1:W]} : wbuf0_q;
    wbuf1_d    = w_sample ? {i_wdata1, wbuf1_q[width-1:W]} : wbuf1_q;
    wcommit0_d = w_done;
    wcommit1_d = wcommit0_q;
    wword_d    = w_done ? (w_cnt_q >> RLg) : wword_q;
    // Port1 word is kept aside since its assembly buffer keeps shifting.
    whold1_d   = wcommit0_q ? wbuf1_q : whold1_q;

    w_active_d = w_active_q;
    w_cnt_d    = w_cnt_q;
    if (i_wreq) begin
      w_active_d = 1'b1;
      w_cnt_d    = '0;
    end else if (w_active_q) begin
      if (w_cnt_q == CW'(NChunk - 1)) w_active_d = 1'b0;
      else                            w_cnt_d    = w_cnt_q + 1'b1;
    end

    if (wcommit0_q) begin
      o_wen   = i_wen0;
      o_waddr = (AW'(i_wreg0) << WLg) | AW'(wword_q);
      o_wdata = wbuf0_q;
    end else begin
      o_wen   = wcommit1_q & i_wen1;
      o_waddr = (AW'(i_wreg1) << WLg) | AW'(wword_q);
      o_wdata = whold1_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active_q <= 1'b0;
      r_cnt_q    <= '0;
      ren0_q     <= 1'b0;
      ren1_q     <= 1'b0;
      rbuf0_q    <= '0;
      rbuf1_q    <= '0;
      w_active_q <= 1'b0;
      w_cnt_q    <= '0;
      wbuf0_q    <= '0;
      wbuf1_q    <= '0;
      whold1_q   <= '0;
      wcommit0_q <= 1'b0;
      wcommit1_q <= 1'b0;
      wword_q    <= '0;
    end else begin
      r_active_q <= r_active_d;
      r_cnt_q    <= r_cnt_d;
      ren0_q     <= ren0_d;
      ren1_q     <= ren1_d;
      rbuf0_q    <= rbuf0_d;
      rbuf1_q    <= rbuf1_d;
      w_active_q <= w_active_d;
      w_cnt_q    <= w_cnt_d;
      wbuf0_q    <= wbuf0_d;
      wbuf1_q    <= wbuf1_d;
      whold1_q   <= whold1_d;
      wcommit0_q <= wcommit0_d;
      wcommit1_q <= wcommit1_d;
      wword_q    <= wword_d;
    end
  end

endmodule

// File: doc/serv_rf_ram_bridge.md
# serv_rf_ram_bridge

Converts the core's narrow two-port register file access stream (W-bit chunks, LSB first) into word accesses on a single-clock RAM with one read port and one write port (`width` bits wide). It sits between the core's RF interface and the RF RAM macro and owns all counter, buffering and port-interleave logic. The GPRs occupy registers 0–31, and CSRs occupy 32–35 when `WITH_CSR`=1. Each register is stored as 32/`width` consecutive RAM words.

## Interface
Parameters:
- `width`: default 8. RAM data width. Must be a power of two, ≤32, and `width`/`W` ≥ 2.
- `W`: default 1. Core chunk width. R = `width`/`W` chunks per RAM word.
- `WITH_CSR`: default 1. Register index width RW = 5+`WITH_CSR`.
- Derived: AW = RW + log2(32/`width`); RAM address = {reg, word}.

Ports:
- `i_clk`  in  1  clock. The block has one clock.
- `i_rst`  in  1  reset. Synchronous, active-high.
- `i_wreq`  in  1  single-cycle pulse that starts a write window.
- `i_rreq`  in  1  single-cycle pulse that starts a read window.
- `o_ready`  out  1  one-cycle pulse; read chunk 0 is valid on `o_rdata0`/`o_rdata1` in this cycle.
- `i_wreg0`, `i_wreg1`  in  RW  write register index per port.
- `i_wen0`, `i_wen1`  in  1  per-port write enable.
- `i_wdata0`, `i_wdata1`  in  W  write chunks.
- `i_rreg0`, `i_rreg1`  in  RW  read register index per port.
- `o_rdata0`, `o_rdata1`  out  W  read chunks.
- `o_waddr`  out  AW  RAM write address.
- `o_wdata`  out  `width`  RAM write data.
- `o_wen`  out  1  RAM write strobe.
- `o_raddr`  out  AW  RAM read address.
- `o_ren`  out  1  RAM read strobe.
- `i_rdata`  in  `width`  RAM read data. Valid the cycle after `o_ren`.

## Operation
- Chunk c (0..32/W−1) of a register maps to word c/R, bits [(c mod R)·W +: W].
- **Read window**
  - `i_rreq` in cycle 0 clears the read counter and arms the window.
  - In cycle 1+kR the block issues a port0 read at {`i_rreg0`, k}.
  - In cycle 2+kR the block issues a port1 read at {`i_rreg1`, k}.
  - k runs from 0 to 32/`width`−1. After the last port1 read, no further `o_ren`.
  - Port0 word k loads into a `width`-bit shift register in cycle 2+kR.
  - Port1 word k is presented by bypass from `i_rdata` in cycle 3+kR. Its remaining chunks come from the port1 shift register.
  - Chunk c appears on both `o_rdata` outputs in cycle 3+c. `o_ready` pulses in cycle 3.
  - `i_rreg*` are sampled at each issue and must stay stable for the whole window.
- **Write window**
  - `i_wreq` in cycle 0 clears the write counter.
  - Chunk c of each port is sampled in cycle 1+c into per-port `width`-bit assembly buffers.
  - When chunk c with (c+1) mod R = 0 is sampled, the word is complete.
  - The port0 word commits the next cycle: `o_wen`=`i_wen0`, `o_waddr`={`i_wreg0`, c/R}.
  - The port1 word commits one cycle after port0, using `i_wen1` and `i_wreg1`.
  - R ≥ 2 guarantees the write port never collides.
  - `i_wen*` and `i_wreg*` are held constant for the window.
  - A port with its enable low produces no `o_wen` in its slots.
  - x0 masking is done upstream and is not repeated here.
- Read and write windows are independent and may overlap. A read-after-write to the same word returns whatever the RAM returns; the block does not forward.
- A new `i_rreq` (or `i_wreq`) during an active window of the same kind restarts that window. Partially assembled write words are discarded.

## Timing
- Reset: `o_ready`=0, `o_ren`=0, `o_wen`=0, `o_rdata*`=0. Both windows become idle, and pending commits are cancelled.
- Reset mid-window: no `o_ren` or `o_wen` from the cycle after `i_rst` is sampled.
- Read latency from `i_rreq` to `o_ready` is 3 cycles. The last chunk appears in cycle 2+32/W.
- Last write commit is in cycle 2+32/W (port1). A new `i_wreq` may follow in the next cycle.
- `o_waddr`, `o_wdata`, `o_raddr` are don't-care when their strobe is low.

## Test plan
- **Read** (`width`=8, `W`=1, `WITH_CSR`=1). Preload x5=0xDEADBEEF, x6=0x12345678; `i_rreq` with rreg0=5, rreg1=6.
  - `o_ren` fires in cycles 1,2,9,10,17,18,25,26.
  - `o_raddr` sequence is 20,24,21,25,22,26,23,27.
  - `o_ready` pulses in cycle 3.
  - Over cycles 3–34, `o_rdata0` serializes 0xDEADBEEF and `o_rdata1` serializes 0x12345678, LSB first.
- **Write**. `i_wreq` with wreg0=7 / 0xA5A5F00F and wreg1=34 / 0x80000004, both enables high.
  - `o_wen` fires in cycles 9,10,17,18,25,26,33,34.
  - First two writes: (28, 0x0F), (136, 0x04).
  - Last two writes: (31, 0xA5), (139, 0x80).
- **Single-port write**. Same write with `i_wen1`=0 → exactly 4 `o_wen`, in cycles 9,17,25,33.
- **Reset mid-write**. `i_rst` asserted in cycle 12 of a write window → `o_wen` stays 0 thereafter. The RAM holds only the cycle-9/10 words.
- **Narrow RAM** (`width`=2). Read of x1=0xFFFFFFFF, x2=0 → `o_ren` high every cycle 1–32; outputs are constant 1 and 0 for 32 cycles.
- **Back-to-back and overlap**. Second `i_rreq` in cycle 35 → `o_ready` in cycle 38 with correct data. A concurrent write window to other registers does not disturb the read data.
